// File: rtl/regfile_writeback.sv
// Register-file writeback queue: a circular FIFO that drains one write per unheld cycle, with operand hazard checking.
// Define WB_BYPASS_EN to forward the youngest pending write to the operands; otherwise hazards are flagged.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef REG_SEL
`define REG_SEL 3
`endif

module regfile_writeback #(
    parameter int DATA_W = `WIDTH,
    parameter int ADDR_W = `REG_SEL,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              hold,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_z,
    output logic [DATA_W-1:0] rf_data_z,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    // Ready ignores a concurrent pop so a full queue never takes a same-cycle push.
    assign wb_ready  = (count != (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = wb_valid && wb_ready;
    assign rf_we     = !empty && !hold && !reset;
    assign pop       = rf_we;
    assign rf_addr_z = q_addr[head];
    assign rf_data_z = q_data[head];
    assign rf_addr_a = rd_addr_a;
    assign rf_addr_b = rd_addr_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= wb_addr;
            q_data[tail] <= wb_data;
        end
    end

    // Scan oldest to youngest; the head is still a match because the file only updates at the edge.
    always_comb begin
        op_a     = rf_data_a;
        op_b     = rf_data_b;
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W+1)'(k) < count) begin
`ifdef WB_BYPASS_EN
                if (q_addr[head + PTR_W'(k)] == rd_addr_a) op_a = q_data[head + PTR_W'(k)];
                if (q_addr[head + PTR_W'(k)] == rd_addr_b) op_b = q_data[head + PTR_W'(k)];
`else
                if (q_addr[head + PTR_W'(k)] == rd_addr_a) hazard_a = 1'b1;
                if (q_addr[head + PTR_W'(k)] == rd_addr_b) hazard_b = 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized bench for regfile_writeback against a queue-based model, with directed scenarios pinned by literals.
module tb_regfile_writeback;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset, wb_valid, wb_ready, hold, rf_we, hazard_a, hazard_b, empty;
    logic [AW-1:0] wb_addr, rf_addr_z, rd_addr_a, rd_addr_b, rf_addr_a, rf_addr_b;
    logic [DW-1:0] wb_data, rf_data_z, rf_data_a, rf_data_b, op_a, op_b;

    regfile_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .hold(hold), .rf_we(rf_we),
        .rf_addr_z(rf_addr_z), .rf_data_z(rf_data_z),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .op_a(op_a), .op_b(op_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .empty(empty));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t mq[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand expectation from the pending list: youngest match wins (forwarding) or any match flags.
    task automatic model_op(input logic [AW-1:0] ra, input logic [DW-1:0] rfd,
                            output logic [DW-1:0] op, output logic hz);
        op = rfd;
        hz = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].a == ra) begin
`ifdef WB_BYPASS_EN
                op = mq[i].d;
`else
                hz = 1'b1;
`endif
            end
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] eo;
        logic eh;
        chk("wb_ready", wb_ready, mq.size() < DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("rf_we", rf_we, (mq.size() > 0) && !hold && !reset);
        if (mq.size() > 0) begin
            chk("rf_addr_z", rf_addr_z, mq[0].a);
            chk("rf_data_z", rf_data_z, mq[0].d);
        end
        chk("rf_addr_a", rf_addr_a, rd_addr_a);
        chk("rf_addr_b", rf_addr_b, rd_addr_b);
        model_op(rd_addr_a, rf_data_a, eo, eh);
        chk("op_a", op_a, eo);
        chk("hazard_a", hazard_a, eh);
        model_op(rd_addr_b, rf_data_b, eo, eh);
        chk("op_b", op_b, eo);
        chk("hazard_b", hazard_b, eh);
    endtask

    task automatic apply(input logic r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic h, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [DW-1:0] fa, input logic [DW-1:0] fb);
        reset = r; wb_valid = v; wb_addr = a; wb_data = d; hold = h;
        rd_addr_a = ra; rd_addr_b = rb; rf_data_a = fa; rf_data_b = fb;
        #1;
        compare_all();
    endtask

    task automatic step();
        bit do_pop, do_push;
        @(posedge clk);
        do_pop  = (mq.size() > 0) && !hold && !reset;
        do_push = wb_valid && (mq.size() < DEPTH);
        if (reset) mq.delete();
        else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{a: wb_addr, d: wb_data});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        apply(1'b0, 1'b0, '0, '0, h, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        step();
    endtask

    initial begin
        reset = 1'b1; wb_valid = 0; wb_addr = 0; wb_data = 0; hold = 0;
        rd_addr_a = 0; rd_addr_b = 0; rf_data_a = 0; rf_data_b = 0;
        @(posedge clk);
        @(negedge clk);
        mq.delete();

        // Post-reset state and single write latency
        idle(1'b0);
        chk("rst_ready", wb_ready, 1); chk("rst_empty", empty, 1);
        chk("rst_we", rf_we, 0); chk("rst_hz", {hazard_a, hazard_b}, 0);
        apply(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, '0, '0, '0, '0);
        step();
        idle(1'b0);
        chk("lat_we", rf_we, 1); chk("lat_addr", rf_addr_z, 3); chk("lat_data", rf_data_z, 8'hA5);
        step();
        idle(1'b0);
        chk("lat_empty", empty, 1);
        step();

        // Hold fills the queue, then drains in order
        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1, '0, '0, '0, '0);
            if (i == 5) chk("full_ready", wb_ready, 0);
            step();
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0);
            chk("drain_we", rf_we, 1); chk("drain_addr", rf_addr_z, i);
            step();
        end
        idle(1'b0);
        chk("drain_done", empty, 1);
        step();

        // Full queue with a pop: no push that cycle, accepted the next
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, AW'(i), DW'(i), 1'b1, '0, '0, '0, '0);
            step();
        end
        apply(1'b0, 1'b1, 3'd6, 8'h66, 1'b0, '0, '0, '0, '0);
        chk("fullpop_ready", wb_ready, 0); chk("fullpop_we", rf_we, 1);
        step();
        apply(1'b0, 1'b1, 3'd6, 8'h66, 1'b0, '0, '0, '0, '0);
        chk("next_ready", wb_ready, 1);
        step();
        for (int i = 0; i < 6; i++) begin idle(1'b0); step(); end

        // Two writes to the same register, operand read against them
        do_reset();
        apply(1'b0, 1'b1, 3'd7, 8'h11, 1'b1, 3'd7, '0, '0, '0); step();
        apply(1'b0, 1'b1, 3'd7, 8'h22, 1'b1, 3'd7, '0, '0, '0); step();
        apply(1'b0, 1'b0, '0, '0, 1'b1, 3'd7, '0, 8'h00, '0);
`ifdef WB_BYPASS_EN
        chk("fwd_op_a", op_a, 8'h22); chk("fwd_hz_a", hazard_a, 0);
`else
        chk("nofwd_op_a", op_a, 8'h00); chk("nofwd_hz_a", hazard_a, 1);
`endif
        step();

        // Reset with pending writes under hold discards them
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, AW'(i + 1), DW'(i), 1'b1, '0, '0, '0, '0);
            step();
        end
        apply(1'b1, 1'b0, '0, '0, 1'b1, '0, '0, '0, '0);
        chk("rstmid_we", rf_we, 0);
        step();
        idle(1'b0);
        chk("rstmid_empty", empty, 1); chk("rstmid_ready", wb_ready, 1); chk("rstmid_we2", rf_we, 0);
        step();
        idle(1'b0);
        chk("rstmid_nowr", rf_we, 0);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 99) < 2), $urandom_range(0, 1), AW'($urandom_range(0, 3)),
                  DW'($urandom), ($urandom_range(0, 99) < 35), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), DW'($urandom), DW'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL provide parameter DATA_W, default `WIDTH, meaning register data width.
REQ-002 The block SHALL provide parameter ADDR_W, default `REG_SEL, meaning register select width.
REQ-003 The block SHALL provide parameter DEPTH, default 4, meaning write-queue entries (power of 2, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 wb_valid  input  1  writeback request present.
REQ-007 wb_ready  output  1  queue can accept; equals not full.
REQ-008 wb_addr  input  ADDR_W  destination register.
REQ-009 wb_data  input  DATA_W  write data.
REQ-010 hold  input  1  inhibit register-file writes this cycle.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rf_addr_z  output  ADDR_W  register-file write address.
REQ-013 rf_data_z  output  DATA_W  register-file write data.
REQ-014 rd_addr_a, rd_addr_b  input  ADDR_W each  operand read addresses; driven unchanged onto rf_addr_a, rf_addr_b (output, ADDR_W).
REQ-015 rf_data_a, rf_data_b  input  DATA_W each  combinational register-file read data.
REQ-016 op_a, op_b  output  DATA_W each  operand values to consumer.
REQ-017 hazard_a, hazard_b  output  1 each  operand depends on a pending write.
REQ-018 empty  output  1  no pending writes.

Function
REQ-019 Queue SHALL be a DEPTH-entry circular FIFO with registered head/tail pointers and an occupancy count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-020 Push SHALL occur when wb_valid and wb_ready; wb_ready SHALL be low exactly when count equals DEPTH, including cycles in which a pop also occurs (no same-cycle push into a full queue).
REQ-021 rf_we SHALL equal (not empty) and (not hold), combinationally; rf_addr_z/rf_data_z SHALL present the head entry; a pop SHALL occur on every cycle rf_we is high.
REQ-022 Minimum latency: a request accepted at edge N SHALL drive rf_we during cycle N+1; no combinational wb_* to rf_* path.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; entries SHALL retire in strict acceptance order.
REQ-024 Multiple pending writes to one address SHALL all be issued in order; no coalescing.
REQ-025 With hold high, queue SHALL retain contents and continue accepting until full.
REQ-026 Operand match SHALL compare rd_addr_x against every valid entry, including the head being written this cycle (the register file updates only at the edge).
REQ-027 empty SHALL equal (count == 0), combinationally from registered count.

Reset
REQ-028 While reset is high at an edge, pointers and count SHALL clear to 0; entry storage is not cleared.
REQ-029 After reset: wb_ready=1, rf_we=0, empty=1, hazard_a=hazard_b=0; pending writes are discarded, including reset asserted mid-drain or with hold high.
REQ-030 rf_we SHALL be 0 in any cycle where reset is high.

Configuration
REQ-031 Macro WB_BYPASS_EN SHALL select operand forwarding.
REQ-032 Defined: op_x SHALL equal data of the youngest valid matching entry, else rf_data_x; hazard_a=hazard_b=0 always.
REQ-033 Undefined: op_x SHALL equal rf_data_x; hazard_x SHALL be 1 when any valid entry matches rd_addr_x; no forwarding logic is synthesized.

Verification
REQ-034 Reset, then push (addr 3, 0xA5) with hold=0 -> rf_we=1, rf_addr_z=3, rf_data_z=0xA5 exactly one cycle later; empty=1 the cycle after.
REQ-035 hold=1, push 5 requests (addr 1..5) -> first 4 accepted, wb_ready=0 on 5th; release hold -> writes 1..4 issued on 4 consecutive cycles, in order.
REQ-036 Full queue, hold=0, wb_valid=1 -> no acceptance in the popping cycle; accepted the next cycle; count never exceeds 4.
REQ-037 WB_BYPASS_EN defined, hold=1, push (7,0x11) then (7,0x22), rd_addr_a=7, rf_data_a=0 -> op_a=0x22, hazard_a=0; undefined -> op_a=0, hazard_a=1.
REQ-038 hold=1, 3 entries pending, assert reset one cycle -> empty=1, wb_ready=1, rf_we=0; release hold -> no writes issued.
